unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-port, fixed-latency unified memory between the processor's instruction-fetch (IF) port and data-memory (DM) port. Data accesses win by default; a starvation guard forces an IF grant after a bounded run of DM grants. Sits between the pipeline's IF/MEM stages and the memory macro in the MiniLab top level. Produces per-port stall signals for hazard logic and registered read data with a one-cycle ack pulse.

## Interface
- ADDR_W, 16, address width of both ports and memory
- DATA_W, 16, data width
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal range 1..15)
- STARVE_LIM, 3, max consecutive DM grants while if_req is pending (legal range 1..15)

- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF read request; held with if_addr stable until if_ack
- if_addr  in  ADDR_W  IF address
- if_rdata  out  DATA_W  registered instruction word
- if_ack  out  1  one-cycle pulse, if_rdata valid this cycle
- if_stall  out  1  if_req & ~if_ack
- dm_req  in  1  DM request; held with addr/we/wdata stable until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  DM address
- dm_wdata  in  DATA_W  DM write data
- dm_rdata  out  DATA_W  registered load data
- dm_ack  out  1  one-cycle pulse, DM transaction complete
- dm_stall  out  1  dm_req & ~dm_ack
- mem_en  out  1  one-cycle memory strobe (registered)
- mem_we  out  1  write enable, valid with mem_en
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after mem_en

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample requests. None -> stay. Else grant per priority, latch owner, we, addr, wdata -> ISSUE.
- Priority: DM wins unless if_req is pending and starve_cnt == STARVE_LIM, then IF wins.
- starve_cnt: on a DM grant with if_req high, increment (saturating at STARVE_LIM); on any IF grant, or DM grant with if_req low, clear.
- ISSUE: mem_en=1, mem_we/addr/wdata from latched values; load wait counter with MEM_LAT -> WAIT.
- WAIT: decrement; at the cycle mem_rdata is valid (MEM_LAT cycles after ISSUE), capture mem_rdata into owner's rdata register if read -> DONE.
- DONE: assert owner's ack for exactly one cycle; requests ignored -> IDLE.
- Writes: same FSM path; dm_rdata not updated; dm_ack pulses in DONE.
- The non-owner port's rdata register is never modified.
- A request dropped before ack (illegal) does not abort the in-flight transaction; ack is still pulsed.

## Timing
- Request sampled in IDLE at cycle t -> mem_en at t+1 -> mem_rdata sampled at t+1+MEM_LAT -> ack high in cycle t+2+MEM_LAT.
- Request-to-ack latency MEM_LAT+2 cycles; IDLE -> IDLE cycle period MEM_LAT+3 cycles per transaction.
- Requester changes req/addr on the edge where it samples ack high; the arbiter's next IDLE cycle sees the new request.
- mem_en is never high in two consecutive cycles; at most one transaction in flight.
- Simultaneous IF and DM requests in IDLE: exactly one granted; loser's stall stays high.
- Stalls are combinational from req and the registered acks; they are low in the ack cycle.
- Reset (any state, including mid-WAIT): next cycle state IDLE, in-flight transaction dropped, starve_cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0.

## Test plan
- IF-only read, MEM_LAT=2, if_addr=0x0010, memory returns 0xBEEF -> mem_en once at t+1 with mem_addr=0x0010, if_ack single pulse at t+4, if_rdata=0xBEEF, dm_rdata stays 0.
- DM write then read, addr 0x0200, wdata 0x1AA -> write: mem_we=1, mem_wdata=0x1AA, dm_ack at t+4, dm_rdata unchanged; read: dm_rdata=0x01AA.
- IF and DM requests raised together in the same cycle -> DM granted first, if_stall high throughout DM transaction, IF granted in the following IDLE; acks 5 cycles apart.
- Continuous DM requests with if_req held high, STARVE_LIM=3 -> grant order DM, DM, DM, IF, DM, ...; starve_cnt clears after the IF grant.
- rst asserted for one cycle during WAIT of a DM read -> no dm_ack, all outputs zero next cycle; a fresh IF request afterwards completes normally.
- MEM_LAT=1 and MEM_LAT=5 builds -> ack latency 3 and 7 cycles respectively, mem_en never high on consecutive cycles.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF and DM ports onto one single-port, fixed-latency memory.
// DM has priority; a starvation counter forces an IF grant after STARVE_LIM DM grants.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t     state, state_nxt;
  owner_t     owner;
  logic       we_q;
  logic [3:0] starve_cnt;
  logic [3:0] wait_cnt;
  logic       any_req;
  logic       if_win;
  logic       last_wait;

  assign any_req   = if_req | dm_req;
  assign if_win    = if_req & (~dm_req | (starve_cnt == 4'(STARVE_LIM)));
  assign last_wait = (wait_cnt == 4'd1);

  assign if_stall  = if_req & ~if_ack;
  assign dm_stall  = dm_req & ~dm_ack;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (last_wait) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, dropping any in-flight access.
    if (rst) begin
      owner      <= OWN_IF;
      we_q       <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          // mem_* registers double as the latched request, so the strobe lands in ISSUE.
          owner    <= if_win ? OWN_IF : OWN_DM;
          we_q     <= ~if_win & dm_we;
          mem_en   <= 1'b1;
          mem_we   <= ~if_win & dm_we;
          mem_addr <= if_win ? if_addr : dm_addr;
          if (!if_win) mem_wdata <= dm_wdata;
          if (if_win || !if_req)                     starve_cnt <= '0;
          else if (starve_cnt != 4'(STARVE_LIM))     starve_cnt <= starve_cnt + 4'd1;
        end
        ISSUE: begin
          mem_we   <= 1'b0;
          wait_cnt <= 4'(MEM_LAT);
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (last_wait) begin
            if (owner == OWN_IF) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              if (!we_q) dm_rdata <= mem_rdata;
              dm_ack <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: a MEM_LAT=2 instance under directed traffic
// plus MEM_LAT=1 and MEM_LAT=5 instances checking latency and strobe spacing.
module tb_unified_mem_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT  = 2;
  localparam int SLIM = 3;

  typedef struct { logic wr; logic [DW-1:0] data; } dm_exp_t;
  typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; int cyc; } grant_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rst_boot;
  logic          if_req, if_ack, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_ack, dm_stall;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [DW-1:0] if_q[$];
  dm_exp_t       dm_q[$];
  grant_t        glog[$];
  logic [DW-1:0] exp_if, exp_dm;
  bit            lat_done [2];

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_LIM(SLIM)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: unwritten words read as addr^5A5A except 0x0010 which holds 0xBEEF.
  logic [DW-1:0] mem [65536];
  bit            mem_vld [65536];
  logic [DW-1:0] rd_pipe [LAT];
  logic          en_d = 1'b0;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_vld[a])       return mem[a];
    if (a == 16'h0010)    return 16'hBEEF;
    return a ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    en_d       <= mem_en;
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_rd(mem_addr) : 16'hDEAD;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      mem_vld[mem_addr] <= 1'b1;
    end
  end
  assign mem_rdata = rd_pipe[LAT-1];

  always @(negedge clk) begin
    if (rst) begin
      exp_if <= '0;
      exp_dm <= '0;
    end else begin
      if (mem_en) begin
        check("mem_en_gap", en_d, 1'b0);
        glog.push_back('{mem_addr, mem_we, mem_wdata, cyc});
      end
      if (if_ack) begin
        if (if_q.size() == 0) check("if_ack_spurious", 1, 0);
        else begin
          check("if_rdata", if_rdata, if_q[0]);
          exp_if <= if_q[0];
          void'(if_q.pop_front());
        end
        check("dm_rdata_hold", dm_rdata, exp_dm);
        if (if_req) check("if_stall_ack", if_stall, 1'b0);
      end
      if (dm_ack) begin
        if (dm_q.size() == 0) check("dm_ack_spurious", 1, 0);
        else begin
          if (dm_q[0].wr) check("dm_rdata_write_hold", dm_rdata, exp_dm);
          else begin
            check("dm_rdata", dm_rdata, dm_q[0].data);
            exp_dm <= dm_q[0].data;
          end
          void'(dm_q.pop_front());
        end
        check("if_rdata_hold", if_rdata, exp_if);
        if (dm_req) check("dm_stall_ack", dm_stall, 1'b0);
      end
    end
  end

  task automatic if_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                         output int lat, output int ack_cyc, output bit stall_ok);
    if_q.push_back(exp);
    if_req = 1'b1; if_addr = a;
    lat = 0; ack_cyc = -1; stall_ok = 1'b1;
    while (lat < 40) begin
      @(negedge clk);
      if (if_ack) begin ack_cyc = cyc; break; end
      if (!if_stall) stall_ok = 1'b0;
      lat++;
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dm_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] exp, output int lat, output int ack_cyc);
    dm_q.push_back('{we, exp});
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
    lat = 0; ack_cyc = -1;
    while (lat < 40) begin
      @(negedge clk);
      if (dm_ack) begin ack_cyc = cyc; break; end
      lat++;
    end
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  initial begin
    int lat, lat2, ac_i, ac_d, t0, n0, n_ack, w;
    bit ok_i, ok_d;
    logic [AW-1:0] order [10];
    rst = 1'b1; rst_boot = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst_boot = 1'b0;
    @(negedge clk);
    check("rst_mem_ctl", {mem_en, mem_we}, 0);
    check("rst_acks", {if_ack, dm_ack}, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    @(posedge clk); #1;

    // IF-only read
    t0 = cyc; n0 = glog.size();
    if_read(16'h0010, 16'hBEEF, lat, ac_i, ok_i);
    check("t1_latency", lat, LAT + 2);
    check("t1_grants", glog.size() - n0, 1);
    check("t1_mem_addr", glog[n0].addr, 16'h0010);
    check("t1_en_cycle", glog[n0].cyc - t0, 1);

    // DM write then read back
    n0 = glog.size();
    dm_op(1'b1, 16'h0200, 16'h01AA, 16'h0000, lat, ac_d);
    check("t2_wr_latency", lat, LAT + 2);
    check("t2_wr_we", glog[n0].we, 1'b1);
    check("t2_wr_wdata", glog[n0].wdata, 16'h01AA);
    check("t2_wr_addr", glog[n0].addr, 16'h0200);
    dm_op(1'b0, 16'h0200, 16'h0000, 16'h01AA, lat, ac_d);
    check("t2_rd_latency", lat, LAT + 2);
    check("t2_rd_we", glog[n0+1].we, 1'b0);

    // Simultaneous requests: DM first, IF in the following IDLE
    n0 = glog.size();
    fork
      if_read(16'h0020, 16'h0020 ^ 16'h5A5A, lat, ac_i, ok_i);
      dm_op(1'b0, 16'h0030, 16'h0000, 16'h0030 ^ 16'h5A5A, lat2, ac_d);
    join
    check("t3_first_dm", glog[n0].addr, 16'h0030);
    check("t3_second_if", glog[n0+1].addr, 16'h0020);
    check("t3_ack_gap", ac_i - ac_d, LAT + 3);
    check("t3_if_stall_held", ok_i, 1'b1);

    // Starvation guard with if_req held through back-to-back DM traffic
    n0 = glog.size();
    order = '{16'h0300, 16'h0301, 16'h0302, 16'h0400, 16'h0303,
              16'h0304, 16'h0305, 16'h0401, 16'h0306, 16'h0307};
    fork
      begin
        if_read(16'h0400, 16'h0400 ^ 16'h5A5A, lat, ac_i, ok_i);
        if_read(16'h0401, 16'h0401 ^ 16'h5A5A, lat, ac_i, ok_i);
      end
      for (int k = 0; k < 8; k++)
        dm_op(1'b0, 16'(16'h0300 + k), 16'h0000, 16'(16'h0300 + k) ^ 16'h5A5A, lat2, ac_d);
    join
    for (int k = 0; k < 10; k++)
      check($sformatf("t4_grant%0d", k), glog[n0+k].addr, order[k]);

    // Reset in the middle of a DM read's WAIT phase
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0500; dm_wdata = 16'h1234;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; dm_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_mem_ctl", {mem_en, mem_we}, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_mem_wdata", mem_wdata, 0);
    check("t5_acks", {if_ack, dm_ack}, 0);
    check("t5_if_rdata", if_rdata, 0);
    check("t5_dm_rdata", dm_rdata, 0);
    n_ack = 0;
    repeat (8) begin
      @(negedge clk);
      if (dm_ack) n_ack++;
    end
    check("t5_no_dm_ack", n_ack, 0);
    @(posedge clk); #1;
    if_read(16'h0600, 16'h0600 ^ 16'h5A5A, lat, ac_i, ok_i);
    check("t5_fresh_if_latency", lat, LAT + 2);

    w = 0;
    while (!(lat_done[0] && lat_done[1]) && w < 500) begin
      @(posedge clk);
      w++;
    end
    check("lat_builds_done", {lat_done[0], lat_done[1]}, 2'b11);
    check("if_queue_empty", if_q.size(), 0);
    check("dm_queue_empty", dm_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Alternate latency builds: back-to-back IF reads on a private memory model
  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int L = (g == 0) ? 1 : 5;
    logic          ireq, iack, istall, dack, dstall, en, we, en_d_l;
    logic [AW-1:0] iaddr, maddr;
    logic [DW-1:0] irdata, drdata, mwdata, mrdata;
    logic [DW-1:0] pipe [L];

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_LIM(SLIM)) u_dut (
      .clk(clk), .rst(rst_boot),
      .if_req(ireq), .if_addr(iaddr), .if_rdata(irdata), .if_ack(iack), .if_stall(istall),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr('0), .dm_wdata('0),
      .dm_rdata(drdata), .dm_ack(dack), .dm_stall(dstall),
      .mem_en(en), .mem_we(we), .mem_addr(maddr), .mem_wdata(mwdata),
      .mem_rdata(mrdata)
    );

    always @(posedge clk) begin
      en_d_l  <= en;
      pipe[0] <= (en && !we) ? (maddr ^ 16'h5A5A) : 16'hDEAD;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mrdata = pipe[L-1];

    always @(negedge clk)
      if (en) check($sformatf("lat%0d_en_gap", L), en_d_l, 1'b0);

    initial begin
      ireq = 1'b0; iaddr = '0;
      @(negedge clk);
      while (rst_boot) @(negedge clk);
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        int n;
        n = 0; ireq = 1'b1; iaddr = 16'(16'h0700 + k);
        while (n < 40) begin
          @(negedge clk);
          if (iack) break;
          n++;
        end
        check($sformatf("lat%0d_latency%0d", L, k), n, L + 2);
        check($sformatf("lat%0d_rdata%0d", L, k), irdata, iaddr ^ 16'h5A5A);
        @(posedge clk); #1;
      end
      ireq = 1'b0;
      lat_done[g] = 1'b1;
    end
  end

endmodule
